// File: rtl/correlator_search_core_if.sv
// rtl/correlator_search_core_if.sv - frame BRAM read port between matcher and frame store
interface correlator_search_core_if #(
    parameter int ADDR_W = 9,
    parameter int LINE_W = 128
);
    logic [ADDR_W-1:0] bram_addr;
    logic [LINE_W-1:0] bram_data;

    modport master (output bram_addr, input bram_data);
    modport slave  (input bram_addr, output bram_data);
endinterface

// File: rtl/correlator_search_core.sv
// rtl/correlator_search_core.sv - XOR-popcount block matcher sweeping an (x,y) offset grid
module correlator_search_core #(
    parameter int LINE_W     = 128,
    parameter int ADDR_W     = 9,
    parameter int SEARCH_W   = 96,
    parameter int SEARCH_H   = 16,
    parameter int PREV_LSB   = 16,
    parameter int OFF_W      = 5,
    parameter int CENTER_OFF = 8,
    parameter int FRAME_OFF  = 256,
    parameter int SUM_W      = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     go,
    input  logic                     abort,
    input  logic                     frame_sel,
    input  logic [OFF_W-1:0]         x_max,
    input  logic [OFF_W-1:0]         y_max,
    correlator_search_core_if.master bram,
    output logic                     busy,
    output logic                     done,
    output logic [SUM_W-1:0]         best_sum,
    output logic [OFF_W-1:0]         best_x,
    output logic [OFF_W-1:0]         best_y
);
    localparam int LINE_CW = $clog2(SEARCH_H);
    localparam int POP_W   = $clog2(SEARCH_W + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] A_PREV = 3'd1;
    localparam logic [2:0] L_PREV = 3'd2;
    localparam logic [2:0] L_CURR = 3'd3;
    localparam logic [2:0] POP    = 3'd4;
    localparam logic [2:0] ACC    = 3'd5;
    localparam logic [2:0] CMP    = 3'd6;
    localparam logic [2:0] DONE   = 3'd7;

    logic [2:0]          state;
    logic [OFF_W-1:0]    x, y, xm, ym, bx, by;
    logic [LINE_CW-1:0]  line;
    logic                fs;
    logic [SEARCH_W-1:0] prev_reg, cur_reg, diff, cur_next;
    logic [POP_W-1:0]    pop_reg, pop_next;
    logic [SUM_W-1:0]    acc, min_sum, acc_next;
    logic [SUM_W:0]      acc_sum;
    logic [ADDR_W-1:0]   cbase, pbase;

    assign cbase = fs ? ADDR_W'(FRAME_OFF) : '0;
    assign pbase = fs ? '0 : ADDR_W'(FRAME_OFF);

    // Previous-frame lines are read around the centring base; every other state
    // presents the y-shifted current-frame line so it is ready when L_CURR samples it.
    always_comb begin
        bram.bram_addr = ADDR_W'(line) + ADDR_W'(y) + cbase;
        if (state == A_PREV)
            bram.bram_addr = ADDR_W'(line) + ADDR_W'(CENTER_OFF) + pbase;
    end

    assign cur_next = SEARCH_W'((bram.bram_data << x) >> (LINE_W - SEARCH_W));
    assign diff     = prev_reg ^ cur_reg;

    always_comb begin
        pop_next = '0;
        for (int i = 0; i < SEARCH_W; i++)
            pop_next = pop_next + POP_W'(diff[i]);
    end

    assign acc_sum  = {1'b0, acc} + {{(SUM_W + 1 - POP_W){1'b0}}, pop_reg};
    assign acc_next = acc_sum[SUM_W] ? '1 : acc_sum[SUM_W-1:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            best_sum <= '0;
            best_x   <= '0;
            best_y   <= '0;
            x        <= '0;
            y        <= '0;
            xm       <= '0;
            ym       <= '0;
            bx       <= '0;
            by       <= '0;
            line     <= '0;
            fs       <= 1'b0;
            prev_reg <= '0;
            cur_reg  <= '0;
            pop_reg  <= '0;
            acc      <= '0;
            min_sum  <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (go && !abort) begin
                            xm      <= x_max;
                            ym      <= y_max;
                            fs      <= frame_sel;
                            x       <= '0;
                            y       <= '0;
                            line    <= '0;
                            acc     <= '0;
                            min_sum <= '1;
                            bx      <= '0;
                            by      <= '0;
                            busy    <= 1'b1;
                            state   <= A_PREV;
                        end
                    end
                    A_PREV: state <= L_PREV;
                    L_PREV: begin
                        prev_reg <= bram.bram_data[PREV_LSB +: SEARCH_W];
                        state    <= L_CURR;
                    end
                    L_CURR: begin
                        cur_reg <= cur_next;
                        state   <= POP;
                    end
                    POP: begin
                        pop_reg <= pop_next;
                        state   <= ACC;
                    end
                    ACC: begin
                        acc  <= acc_next;
                        line <= line + 1'b1;
                        state <= (line < LINE_CW'(SEARCH_H - 1)) ? A_PREV : CMP;
                    end
                    CMP: begin
                        // Strict compare: on ties the earlier offset in scan order wins.
                        if (acc < min_sum) begin
                            min_sum <= acc;
                            bx      <= x;
                            by      <= y;
                        end
                        acc  <= '0;
                        line <= '0;
                        if (x == xm) begin
                            x <= '0;
                            if (y == ym) begin
                                state <= DONE;
                            end else begin
                                y     <= y + 1'b1;
                                state <= A_PREV;
                            end
                        end else begin
                            x     <= x + 1'b1;
                            state <= A_PREV;
                        end
                    end
                    DONE: begin
                        done     <= 1'b1;
                        best_sum <= min_sum;
                        best_x   <= bx;
                        best_y   <= by;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_correlator_search_core.sv
// tb/tb_correlator_search_core.sv - directed bench for correlator_search_core
module tb_correlator_search_core;
    logic clk, resetn, go1, go2, abort, frame_sel;
    logic [4:0]  x_max, y_max;
    logic        busy1, done1, busy2, done2;
    logic [15:0] best_sum1;
    logic [9:0]  best_sum2;
    logic [4:0]  best_x1, best_y1, best_x2, best_y2;
    logic [127:0] mem [0:511];
    int n_vec = 0;
    int n_err = 0;

    correlator_search_core_if #(.ADDR_W(9), .LINE_W(128)) bif1 ();
    correlator_search_core_if #(.ADDR_W(9), .LINE_W(128)) bif2 ();

    correlator_search_core dut1 (
        .clk(clk), .resetn(resetn), .go(go1), .abort(abort), .frame_sel(frame_sel),
        .x_max(x_max), .y_max(y_max), .bram(bif1.master), .busy(busy1), .done(done1),
        .best_sum(best_sum1), .best_x(best_x1), .best_y(best_y1)
    );

    correlator_search_core #(.SUM_W(10)) dut2 (
        .clk(clk), .resetn(resetn), .go(go2), .abort(abort), .frame_sel(frame_sel),
        .x_max(x_max), .y_max(y_max), .bram(bif2.master), .busy(busy2), .done(done2),
        .best_sum(best_sum2), .best_x(best_x2), .best_y(best_y2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bif1.bram_data <= mem[bif1.bram_addr];
        bif2.bram_data <= mem[bif2.bram_addr];
    end

    function automatic logic [31:0] h(input int k);
        logic [31:0] v;
        v = 32'(k) * 32'h9E3779B1;
        v = v ^ (v >> 15);
        v = v * 32'h85EBCA6B;
        v = v ^ (v >> 13);
        return v;
    endfunction

    function automatic logic [95:0] pat(input int l);
        return {h(3 * l + 1), h(3 * l + 2), h(3 * l + 3)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Current frame holds the previous-frame window displaced by (xb,yb); other lines are noise.
    task automatic load_shift(input int xb, input int yb, input logic fs);
        int cb, pb;
        cb = fs ? 256 : 0;
        pb = fs ? 0 : 256;
        for (int a = 0; a < 512; a++) mem[a] = '0;
        for (int a = 0; a < 20; a++)
            mem[cb + a] = {h(1000 + 4 * a), h(1001 + 4 * a), h(1002 + 4 * a), h(1003 + 4 * a)};
        for (int l = 0; l < 16; l++) begin
            mem[pb + 8 + l] = {16'h0, pat(l), 16'h0};
            mem[cb + l + yb] = {pat(l), 32'h0} >> xb;
        end
    endtask

    task automatic fill(input logic fs, input logic [127:0] pw, input logic [127:0] cw);
        int cb, pb;
        cb = fs ? 256 : 0;
        pb = fs ? 0 : 256;
        for (int a = 0; a < 512; a++) mem[a] = '0;
        for (int l = 0; l < 16; l++) mem[pb + 8 + l] = pw;
        for (int a = 0; a < 20; a++) mem[cb + a] = cw;
    endtask

    // Returns one time unit after the edge that samples go (cycle 1 of the sweep).
    task automatic start(input int which);
        @(negedge clk);
        if (which == 1) go1 = 1'b1; else go2 = 1'b1;
        @(posedge clk);
        #1;
        go1 = 1'b0;
        go2 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int cyc0, input int exp, input string tag);
        int cyc;
        logic d;
        cyc = cyc0;
        d = (which == 1) ? done1 : done2;
        while (!d && cyc < exp + 50) begin
            @(posedge clk);
            #1;
            cyc++;
            d = (which == 1) ? done1 : done2;
        end
        check({tag, "_latency"}, cyc, exp);
        check({tag, "_busy_at_done"}, (which == 1) ? busy1 : busy2, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, (which == 1) ? done1 : done2, 1'b0);
    endtask

    task automatic no_done(input int n, input string tag);
        int cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done1) cnt++;
        end
        check(tag, cnt, 0);
    endtask

    task automatic check_best1(input string tag, input int s, input int bx, input int by);
        check({tag, "_sum"}, best_sum1, s);
        check({tag, "_x"}, best_x1, bx);
        check({tag, "_y"}, best_y1, by);
    endtask

    initial begin
        resetn = 1'b0; go1 = 1'b0; go2 = 1'b0; abort = 1'b0; frame_sel = 1'b1;
        x_max = 5'd3; y_max = 5'd3;
        for (int a = 0; a < 512; a++) mem[a] = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);
        check_best1("rst", 0, 0, 0);
        check("rst_addr", bif1.bram_addr, 0);

        // displaced window, current frame in the upper slot
        load_shift(2, 1, 1'b1);
        frame_sel = 1'b1;
        start(1);
        check("fs1_addr_prev", bif1.bram_addr, 8);
        @(posedge clk); #1;
        check("fs1_addr_curr", bif1.bram_addr, 256);
        wait_done(1, 2, 16 * 81 + 2, "shift21");
        check_best1("shift21", 0, 2, 1);

        // swapped slots plus a go pulse while busy
        load_shift(3, 2, 1'b0);
        frame_sel = 1'b0;
        start(1);
        check("fs0_addr_prev", bif1.bram_addr, 264);
        @(posedge clk); #1;
        check("fs0_addr_curr", bif1.bram_addr, 0);
        go1 = 1'b1;
        @(posedge clk); #1;
        go1 = 1'b0;
        wait_done(1, 3, 16 * 81 + 2, "shift32");
        check_best1("shift32", 0, 3, 2);
        no_done(200, "busy_go_ignored");

        // identical all-ones frames: every offset ties at zero
        fill(1'b1, '1, '1);
        frame_sel = 1'b1;
        start(1);
        wait_done(1, 1, 16 * 81 + 2, "ident");
        check_best1("ident", 0, 0, 0);

        // alternating bits: odd x all match, earliest (1,0) must win
        fill(1'b1, {32{4'hA}}, {32{4'h5}});
        start(1);
        wait_done(1, 1, 16 * 81 + 2, "tie");
        check_best1("tie", 0, 1, 0);

        // single offset, full mismatch on every line
        x_max = 5'd0; y_max = 5'd0;
        start(1);
        wait_done(1, 1, 81 + 2, "single");
        check_best1("single", 1536, 0, 0);

        // abort mid-sweep, then abort+go together, then a clean sweep
        load_shift(2, 1, 1'b1);
        x_max = 5'd3; y_max = 5'd3;
        start(1);
        repeat (39) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy1, 1'b0);
        check_best1("abort_hold", 1536, 0, 0);
        no_done(200, "abort_no_done");
        @(negedge clk);
        go1 = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        go1 = 1'b0; abort = 1'b0;
        check("abort_wins", busy1, 1'b0);
        start(1);
        wait_done(1, 1, 16 * 81 + 2, "post_abort");
        check_best1("post_abort", 0, 2, 1);

        // saturating accumulator on the narrow instance
        fill(1'b1, '1, '0);
        x_max = 5'd1; y_max = 5'd0;
        start(2);
        wait_done(2, 1, 2 * 81 + 2, "sat");
        check("sat_sum", best_sum2, 1023);
        check("sat_x", best_x2, 0);
        check("sat_y", best_y2, 0);

        // reset mid-sweep clears results
        load_shift(2, 1, 1'b1);
        x_max = 5'd3; y_max = 5'd3;
        start(1);
        repeat (50) begin @(posedge clk); #1; end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        check("mid_rst_busy", busy1, 1'b0);
        check("mid_rst_done", done1, 1'b0);
        check_best1("mid_rst", 0, 0, 0);
        check("mid_rst_sum2", best_sum2, 0);
        check("mid_rst_addr", bif1.bram_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
